// File: rtl/ex_issue_stage_if.sv
// Bundle of the issue stage's upstream, writeback, ALU and downstream signals.
// The master side is the surrounding pipeline; the slave side is the issue stage.
interface ex_issue_stage_if #(
  parameter int WIDTH = 32
);
  // Upstream (in_*) and downstream (out_*) use valid/ready handshakes.
  // A transfer happens on a rising edge where both valid and ready are high.
  // Ready never depends on valid, so there is no combinational loop.
  // A producer holding valid keeps its payload stable until the transfer.
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [WIDTH-1:0] in_rs1_data;
  logic [WIDTH-1:0] in_rs2_data;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [31:0]      inst;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             dbg_wait_wb;

  modport master (
    output in_valid, in_inst, in_rs1_data, in_rs2_data,
    output wb_valid, wb_rd, wb_data, alu_out, out_ready, flush,
    input  in_ready, a, b, inst, out_valid, dbg_wait_wb
  );

  modport slave (
    input  in_valid, in_inst, in_rs1_data, in_rs2_data,
    input  wb_valid, wb_rd, wb_data, alu_out, out_ready, flush,
    output in_ready, a, b, inst, out_valid, dbg_wait_wb
  );
endinterface

// File: rtl/ex_issue_stage.sv
// Execute issue stage: registers ALU operands with forwarding from the ALU and
// the writeback bus, and stalls on load-use style hazards until writeback.
module ex_issue_stage #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  ex_issue_stage_if.slave bus
);
  typedef enum logic {RUN = 1'b0, WAIT_WB = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [4:0]       pending_rd_q, pending_rd_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [31:0]      inst_q, inst_d;

  logic [6:0] held_op;
  logic [4:0] held_rd, rs1, rs2;
  logic       held_fwd, held_slow, out_fire, slow_hazard, in_ready, accept;
  logic       alu_fwd_en, wb_fwd_en;

  assign held_op = inst_q[6:0];
  assign held_rd = inst_q[11:7];
  assign rs1     = bus.in_inst[19:15];
  assign rs2     = bus.in_inst[24:20];

  assign held_fwd  = (held_op == 7'b0110011) || (held_op == 7'b0010011);
  assign held_slow = (held_op == 7'b0000011) || (held_op == 7'b0110111) ||
                     (held_op == 7'b0010111) || (held_op == 7'b1101111) ||
                     (held_op == 7'b1100111);

  assign out_fire    = out_valid_q && bus.out_ready;
  assign slow_hazard = out_valid_q && held_slow && (held_rd != 5'd0) &&
                       ((held_rd == rs1) || (held_rd == rs2));
  assign in_ready    = !rst && !bus.flush && (state_q == RUN) &&
                       (!out_valid_q || bus.out_ready) && !slow_hazard;
  assign accept      = bus.in_valid && in_ready;

  // The ALU result is only usable when the held instruction leaves this cycle.
  assign alu_fwd_en = out_fire && held_fwd && (held_rd != 5'd0);
  assign wb_fwd_en  = bus.wb_valid && (bus.wb_rd != 5'd0);

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    inst_d       = inst_q;
    out_valid_d  = out_valid_q;
    state_d      = state_q;
    pending_rd_d = pending_rd_q;

    if (accept) begin
      inst_d      = bus.in_inst;
      out_valid_d = 1'b1;
      if (alu_fwd_en && (held_rd == rs1))        a_d = bus.alu_out;
      else if (wb_fwd_en && (bus.wb_rd == rs1))  a_d = bus.wb_data;
      else                                       a_d = bus.in_rs1_data;
      if (alu_fwd_en && (held_rd == rs2))        b_d = bus.alu_out;
      else if (wb_fwd_en && (bus.wb_rd == rs2))  b_d = bus.wb_data;
      else                                       b_d = bus.in_rs2_data;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (!bus.flush && slow_hazard && out_fire) begin
          state_d      = WAIT_WB;
          pending_rd_d = held_rd;
        end
      end
      WAIT_WB: begin
        if (bus.flush || (bus.wb_valid && (bus.wb_rd == pending_rd_q))) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pending_rd_q <= 5'd0;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      inst_q       <= 32'h00000013;
    end else begin
      state_q      <= state_d;
      pending_rd_q <= pending_rd_d;
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      inst_q       <= inst_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.inst        = inst_q;
  assign bus.dbg_wait_wb = (state_q == WAIT_WB);
endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: upstream (decode) handshake.
REQ-005 SHALL have ports in_inst input 32, in_rs1_data input WIDTH, in_rs2_data input WIDTH: decoded instruction and register-file read data.
REQ-006 SHALL have ports wb_valid input 1, wb_rd input 5, wb_data input WIDTH: writeback bus.
REQ-007 SHALL have port alu_out input WIDTH: combinational result of the downstream ALU for the instruction currently held.
REQ-008 SHALL have ports a output WIDTH, b output WIDTH, inst output 32: registered ALU operands and instruction.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-010 SHALL have port flush input 1: discard held and incoming instruction.

Function
REQ-011 SHALL decode rs1=in_inst[19:15], rs2=in_inst[24:20], rd=inst[11:7]; hazard checks on rs1/rs2 unconditional, except index 0 never matches.
REQ-012 SHALL classify held inst: FWD writer = opcode 0110011 or 0010011; SLOW writer = opcode 0000011, 0110111, 0010111, 1101111, 1100111; all others non-writers.
REQ-013 SHALL accept when in_valid && in_ready; in_ready = !rst && !flush && state==RUN && (!out_valid || out_ready) && !slow_hazard.
REQ-014 SHALL assert slow_hazard when held inst is valid SLOW writer with rd!=0 matching in rs1 or rs2.
REQ-015 SHALL on slow_hazard with out handshake firing, latch pending_rd=held rd and enter WAIT_WB.
REQ-016 SHALL leave WAIT_WB for RUN the cycle after wb_valid with wb_rd==pending_rd; in_ready low throughout WAIT_WB.
REQ-017 SHALL select each operand on capture with priority: (1) held inst valid FWD writer, rd!=0, rd matches, out handshake firing -> alu_out; (2) wb_valid, wb_rd!=0, wb_rd matches -> wb_data; (3) in_rs*_data.
REQ-018 SHALL register a, b, inst and set out_valid=1 on acceptance; latency in_valid accept to out_valid = 1 cycle.
REQ-019 SHALL hold a, b, inst stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid after out handshake with no concurrent acceptance; a, b, inst retain last values.
REQ-021 SHALL support back-to-back accept and drain in same cycle (full throughput, one per cycle).
REQ-022 SHALL on flush: out_valid=0 next cycle, state=RUN, no acceptance that cycle; flush overrides in_valid and hazards.
REQ-023 SHALL pass b straight through regardless of ALU immediate use; operand b forwarding applies to rs2 field only.

Reset
REQ-024 SHALL, on rst high at a clock edge: out_valid=0, a=0, b=0, inst=32'h00000013, state=RUN, pending_rd=0.
REQ-025 SHALL hold in_ready=0 while rst high; rst mid-stall discards WAIT_WB and held inst.
REQ-026 SHALL give rst priority over flush and all handshakes.

Verification
REQ-027 Reset: rst=1 one cycle with in_valid=1 -> out_valid=0, inst=32'h00000013, no capture.
REQ-028 Back-to-back FWD: held add x5 (out_ready=1, alu_out=0x0000_0007), incoming addi x6,x5,1 with in_rs1_data=0x0 -> a=0x0000_0007 next cycle.
REQ-029 WB forward: wb_valid=1, wb_rd=3, wb_data=0xDEAD_BEEF, incoming uses rs2=3 -> b=0xDEAD_BEEF; wb_rd=0 case -> b=in_rs2_data.
REQ-030 Load-use: held lw x4, incoming add x7,x4,x1 -> in_ready=0 until cycle after wb_valid/wb_rd=4, then accepted with a=wb_data.
REQ-031 Backpressure: out_ready=0 for 3 cycles -> a, b, inst unchanged, in_ready=0, out_valid=1.
REQ-032 Flush during WAIT_WB -> out_valid=0, state=RUN next cycle, in_ready=1 following cycle.
